packed_frame_tx: RTL

//   Transmit side of the packed-array serial link: accepts one packed word (a 6-bit fm field
//   [3:2][3:1] plus a 32-bit int sw field) over a valid/ready handshake and serializes it.

---
 rtl/packed_frame_tx.sv | 120 ++++++++++++
 1 files changed

// File: rtl/packed_frame_tx.sv
// Serializer for one packed {fm, sw} word: start bit, data MSB-first, even parity, stop bit.
// Each line bit is held for BIT_CYCLES clocks; outputs are registered, in_ready is decoded.
module packed_frame_tx #(
    parameter int FM_W       = 6,
    parameter int SW_W       = 32,
    parameter int BIT_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FM_W-1:0] fm_i,
    input  logic [SW_W-1:0] sw_i,
    output logic            tx_o,
    output logic            busy_o,
    output logic            done_o
);

    // Handshake: a word transfers on a rising edge where in_valid && in_ready.
    // in_ready depends only on state (and rst), never on in_valid.
    localparam int D_W = FM_W + SW_W;
    localparam logic [7:0] LAST_CYC = 8'(BIT_CYCLES - 1);
    localparam logic [5:0] LAST_BIT = 6'(D_W - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]     state;
    logic [7:0]     cyc_cnt;
    logic [5:0]     bit_cnt;
    logic [D_W-1:0] shreg;
    logic           par;
    logic           bit_end;

    assign bit_end  = (cyc_cnt == LAST_CYC);
    assign in_ready = (state == S_IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cyc_cnt <= 8'd0;
            bit_cnt <= 6'd0;
            shreg   <= '0;
            par     <= 1'b0;
            tx_o    <= 1'b1;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        shreg   <= {fm_i, sw_i};
                        par     <= ^{fm_i, sw_i};
                        state   <= S_START;
                        cyc_cnt <= 8'd0;
                        tx_o    <= 1'b0;
                        busy_o  <= 1'b1;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state   <= S_DATA;
                        cyc_cnt <= 8'd0;
                        bit_cnt <= 6'd0;
                        tx_o    <= shreg[D_W-1];
                    end else begin
                        cyc_cnt <= cyc_cnt + 8'd1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        cyc_cnt <= 8'd0;
                        if (bit_cnt == LAST_BIT) begin
                            state <= S_PARITY;
                            tx_o  <= par;
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                            shreg   <= {shreg[D_W-2:0], 1'b0};
                            tx_o    <= shreg[D_W-2];
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 8'd1;
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        state   <= S_STOP;
                        cyc_cnt <= 8'd0;
                        tx_o    <= 1'b1;
                        // With one clock per bit the first STOP cycle is also its last.
                        done_o  <= (LAST_CYC == 8'd0);
                    end else begin
                        cyc_cnt <= cyc_cnt + 8'd1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        state   <= S_IDLE;
                        cyc_cnt <= 8'd0;
                        busy_o  <= 1'b0;
                    end else begin
                        cyc_cnt <= cyc_cnt + 8'd1;
                        done_o  <= ((cyc_cnt + 8'd1) == LAST_CYC);
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    cyc_cnt <= 8'd0;
                    tx_o    <= 1'b1;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule
